// File: rtl/alu_pkg.sv
// Shared ALU definitions for the datapath.
// Opcode encoding and the multiply handshake FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_RSVD  = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_MUL   = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// o_acc_next carries the accumulator including the current step.
module seq_mult_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_done
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_acc_next = r_mplr[0] ? r_acc + r_mcand : r_acc;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign o_acc_next = w_acc_next;
  assign o_done     = i_run && w_last;

  // Load operands on start, then shift-add once per running cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_mplr  <= i_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Word-wide EX-stage ALU with registered result and N/Z/V/C flags.
// Single-cycle logic/arith ops plus an iterative multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  alu_op_e          w_op;
  logic             w_load;
  logic             w_run;
  logic             w_single;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_v;
  logic             w_alu_c;
  logic [WIDTH-1:0] w_wb_res;
  logic             w_wb_en;

  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_n;
  logic             r_z;
  logic             r_v;
  logic             r_c;

  assign w_op     = alu_op_e'(cntrl);
  assign w_is_sub = (w_op == ALU_SUB);
  assign w_b_eff  = w_is_sub ? ~B : B;
  assign w_sum    = {1'b0, A} + {1'b0, w_b_eff}
                  + {{WIDTH{1'b0}}, w_is_sub};

  seq_mult_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mult (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_run      (w_run),
    .i_a        (A),
    .i_b        (B),
    .o_acc_next (w_acc_next),
    .o_done     (w_mul_done)
  );

  // Single-cycle result and arithmetic flags.
  always_comb begin
    w_alu_res = '0;
    w_alu_v   = 1'b0;
    w_alu_c   = 1'b0;
    unique case (w_op)
      ALU_PASSB: w_alu_res = B;
      ALU_ADD, ALU_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (A[WIDTH-1] == w_b_eff[WIDTH-1])
                 && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND:  w_alu_res = A & B;
      ALU_OR:   w_alu_res = A | B;
      ALU_XOR:  w_alu_res = A ^ B;
      ALU_RSVD: w_alu_res = '0;
      ALU_MUL:  w_alu_res = '0;
      default:  w_alu_res = '0;
    endcase
  end

  // Handshake FSM: accept ops in IDLE, stall while multiplying.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_run        = 1'b0;
    w_single     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (w_op == ALU_MUL) begin
            w_load       = 1'b1;
            w_state_next = MUL;
          end else begin
            w_single = 1'b1;
          end
        end
      end
      MUL: begin
        w_run = 1'b1;
        if (w_mul_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_wb_en  = w_single || w_mul_done;
  assign w_wb_res = w_single ? w_alu_res : w_acc_next;

  // Result/flag registers, written only when an op completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_valid <= w_wb_en;
      if (w_wb_en) begin
        r_result <= w_wb_res;
        r_n      <= w_wb_res[WIDTH-1];
        r_z      <= (w_wb_res == '0);
        r_v      <= w_single && w_alu_v;
        r_c      <= w_single && w_alu_c;
      end
    end
  end

  assign result    = r_result;
  assign valid     = r_valid;
  assign busy      = (r_state == MUL);
  assign negative  = r_n;
  assign zero      = r_z;
  assign overflow  = r_v;
  assign carry_out = r_c;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: vector table + scoreboard queue,
// multiply latency/busy sequences, and an 8-bit reset-abort case.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [63:0] a, b;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        valid, busy, n, z, v, c;

  logic       reset8, start8;
  logic [7:0] a8, b8;
  logic [2:0] cntrl8;
  logic [7:0] result8;
  logic       valid8, busy8, n8, z8, v8, c8;

  seq_alu #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A(a), .B(b), .cntrl(cntrl),
    .result(result), .valid(valid), .busy(busy),
    .negative(n), .zero(z), .overflow(v), .carry_out(c)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8),
    .A(a8), .B(b8), .cntrl(cntrl8),
    .result(result8), .valid(valid8), .busy(busy8),
    .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
  );

  typedef struct {
    logic [63:0] res;
    logic        n, z, v, c;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a, b;
    exp_t        e;
  } vec_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   v8cnt    = 0;

  task automatic chk(string name, logic [71:0] act,
                     logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // Scoreboard: every valid pulse consumes one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0h required=none",
                 result);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", 72'(result), 72'(e.res));
        chk("sb_flags", 72'({n, z, v, c}),
            72'({e.n, e.z, e.v, e.c}));
      end
    end
  end

  always @(negedge clk) if (valid8) v8cnt++;

  vec_t tbl[12];

  task automatic run_mul(input logic [63:0] ma,
                         input logic [63:0] mb,
                         input logic [63:0] er,
                         input bit          inject);
    exp_t e;
    int   cyc;
    int   bc;
    e = '{er, er[63], (er == 64'd0), 1'b0, 1'b0};
    sbq.push_back(e);
    start = 1'b1; cntrl = 3'b111; a = ma; b = mb;
    @(negedge clk);
    start = 1'b0; cntrl = 3'b010;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cyc = 1;
    bc  = 0;
    while (!valid && cyc < 200) begin
      if (busy) bc++;
      if (inject && cyc == 10) begin
        start = 1'b1; cntrl = 3'b010;
        a = 64'd1; b = 64'd1;
      end
      if (inject && cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("mul_latency", 72'(cyc), 72'd65);
    chk("mul_busy_cycles", 72'(bc), 72'd64);
    chk("mul_busy_at_valid", 72'(busy), 72'd0);
    @(negedge clk);
    chk("mul_valid_pulse", 72'({valid, busy}), 72'd0);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{3'b011, 64'd5, 64'd5,
                '{64'd0, 1'b0, 1'b1, 1'b0, 1'b1}};
    tbl[2]  = '{3'b011, 64'd3, 64'd5,
                '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                '{64'd0, 1'b0, 1'b1, 1'b0, 1'b1}};
    tbl[4]  = '{3'b000, 64'd77, 64'h8000_0000_0000_0000,
                '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{3'b001, 64'd12, 64'd34,
                '{64'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{3'b100, 64'hF0F0, 64'hFF00,
                '{64'hF000, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{3'b101, 64'hF0F0, 64'h0F0F,
                '{64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{3'b110, 64'hFFFF, 64'hFFFF,
                '{64'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{3'b011, 64'h8000_0000_0000_0000, 64'd1,
                '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[10] = '{3'b010, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000,
                '{64'd0, 1'b0, 1'b1, 1'b1, 1'b1}};
    tbl[11] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};

    reset = 1'b1; start = 1'b1; cntrl = 3'b010;
    a = 64'd5; b = 64'd7;
    reset8 = 1'b1; start8 = 1'b0; cntrl8 = 3'b000;
    a8 = 8'd0; b8 = 8'd0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", 72'({result, valid, busy, n, z, v, c}),
          72'd0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset_release", 72'({result, valid, busy, n, z, v, c}),
        72'd0);

    for (int i = 0; i < 12; i++) begin
      start = 1'b1;
      cntrl = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      sbq.push_back(tbl[i].e);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("table_drained", 72'(sbq.size()), 72'd0);

    run_mul(64'h1234, 64'h10, 64'h12340, 1'b1);
    sbq.push_back('{64'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    start = 1'b1; cntrl = 3'b010; a = 64'd1; b = 64'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("add_after_mul", 72'(sbq.size()), 72'd0);

    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd1, 1'b0);
    run_mul(64'd0, 64'hDEAD_BEEF, 64'd0, 1'b0);
    chk("mul_drained", 72'(sbq.size()), 72'd0);

    reset8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; cntrl8 = 3'b111; a8 = 8'd3; b8 = 8'd4;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd99; b8 = 8'd99;
    @(negedge clk);
    @(negedge clk);
    chk("w8_busy_mid", 72'(busy8), 72'd1);
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    chk("w8_after_rst", 72'({result8, valid8, busy8}), 72'd0);
    repeat (12) @(negedge clk);
    chk("w8_no_valid", 72'(v8cnt), 72'd0);
    chk("w8_idle", 72'({result8, busy8}), 72'd0);

    start8 = 1'b1; cntrl8 = 3'b111; a8 = 8'd3; b8 = 8'd4;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!valid8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("w8_latency", 72'(cyc), 72'd9);
    chk("w8_result", 72'(result8), 72'd12);
    chk("w8_flags", 72'({n8, z8, v8, c8}), 72'd0);
    @(negedge clk);
    chk("w8_one_valid", 72'(v8cnt), 72'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
